// File: rtl/ecc_enc_dec.sv
// SECDED extended-Hamming codec (N = 8/16/32): encode, decode, or encode-noise-decode.
// Full-channel mode is built only when ECC_FULL_CHANNEL_EN is defined.
module ecc_enc_dec #(
  parameter int AMBA_WORD = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AMBA_WORD-1:0] CTRL,
  input  logic [AMBA_WORD-1:0] DATA_IN,
  input  logic [AMBA_WORD-1:0] CODEWORD_WIDTH,
  input  logic [AMBA_WORD-1:0] NOISE,
  output logic [AMBA_WORD-1:0] data_out,
  output logic [1:0]           num_of_errors,
  output logic                 operation_done,
  output logic                 busy
);

`ifdef ECC_FULL_CHANNEL_EN
  typedef enum logic [1:0] {S_IDLE, S_ENC, S_CHAN, S_DEC} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ENC, S_DEC} state_t;
`endif

  // Data occupies the non-power-of-two indices below n, lowest index first.
  function automatic logic [AMBA_WORD-1:0] f_encode(input logic [AMBA_WORD-1:0] data, input int n);
    logic [AMBA_WORD-1:0] cw;
    logic [4:0]           k;
    logic                 par;
    int                   p;
    cw = '0;
    k  = '0;
    for (int m = 3; m < 32; m++) begin
      if ((m < n) && ((m & (m - 1)) != 0)) begin
        cw[5'(m)] = data[k];
        k = k + 5'd1;
      end
    end
    for (int b = 0; b < 5; b++) begin
      p   = 1 << b;
      par = 1'b0;
      for (int m = 1; m < 32; m++) begin
        if (((m & p) != 0) && (m != p)) par = par ^ cw[5'(m)];
      end
      if (p < n) cw[5'(p)] = par;
    end
    cw[0] = ^cw[AMBA_WORD-1:1];
    return cw;
  endfunction

  // Returns {error_count, extracted_data}; cw must already be masked to n bits.
  function automatic logic [AMBA_WORD+1:0] f_decode(input logic [AMBA_WORD-1:0] cw_in, input int n);
    logic [AMBA_WORD-1:0] cw;
    logic [AMBA_WORD-1:0] data;
    logic [4:0]           s;
    logic [4:0]           k;
    logic                 par;
    logic [1:0]           err;
    cw   = cw_in;
    data = '0;
    s    = '0;
    k    = '0;
    for (int m = 1; m < 32; m++) begin
      if (cw[5'(m)]) s = s ^ 5'(m);
    end
    par = ^cw;
    if (par) begin
      cw[s] = ~cw[s];
      err   = 2'd1;
    end else if (s != 5'd0) begin
      err = 2'd2;
    end else begin
      err = 2'd0;
    end
    for (int m = 3; m < 32; m++) begin
      if ((m < n) && ((m & (m - 1)) != 0)) begin
        data[k] = cw[5'(m)];
        k = k + 5'd1;
      end
    end
    return {err, data};
  endfunction

  state_t               r_state;
  logic [1:0]           r_op;
  logic [1:0]           r_width;
  logic [AMBA_WORD-1:0] r_din;
  logic [AMBA_WORD-1:0] r_work;
  logic [AMBA_WORD-1:0] r_dout;
  logic [1:0]           r_nerr;
  logic                 r_done;
`ifdef ECC_FULL_CHANNEL_EN
  logic [AMBA_WORD-1:0] r_noise;
`endif

  int                   w_n;
  logic [AMBA_WORD-1:0] w_mask;
  logic [AMBA_WORD-1:0] w_enc;
  logic [AMBA_WORD-1:0] w_dec_src;
  logic [AMBA_WORD-1:0] w_dec_data;
  logic [1:0]           w_dec_err;
  logic                 w_unused;

  always_comb begin
    w_n    = 32;
    w_mask = '1;
    case (r_width)
      2'b00: begin w_n = 8;  w_mask = AMBA_WORD'(32'h0000_00FF); end
      2'b01: begin w_n = 16; w_mask = AMBA_WORD'(32'h0000_FFFF); end
      default: ;
    endcase
  end

  // A plain decode reads the captured input; full channel reads the noisy work register.
  assign w_enc                   = f_encode(r_din, w_n);
  assign w_dec_src               = (r_op == 2'b01) ? (r_din & w_mask) : r_work;
  assign {w_dec_err, w_dec_data} = f_decode(w_dec_src, w_n);

`ifdef ECC_FULL_CHANNEL_EN
  assign w_unused = ^{CTRL[AMBA_WORD-1:2], CODEWORD_WIDTH[AMBA_WORD-1:2]};
`else
  assign w_unused = ^{CTRL[AMBA_WORD-1:2], CODEWORD_WIDTH[AMBA_WORD-1:2], NOISE};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_width <= '0;
      r_din   <= '0;
      r_work  <= '0;
      r_dout  <= '0;
      r_nerr  <= '0;
      r_done  <= 1'b0;
`ifdef ECC_FULL_CHANNEL_EN
      r_noise <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= CTRL[1:0];
            r_din   <= DATA_IN;
            r_width <= CODEWORD_WIDTH[1:0];
`ifdef ECC_FULL_CHANNEL_EN
            r_noise <= NOISE;
`endif
            r_state <= (CTRL[1:0] == 2'b01) ? S_DEC : S_ENC;
          end
        end
        S_ENC: begin
          r_work <= w_enc;
          if (r_op[1]) begin
`ifdef ECC_FULL_CHANNEL_EN
            r_state <= S_CHAN;
`else
            r_dout  <= '0;
            r_nerr  <= 2'd0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
`endif
          end else begin
            r_dout  <= w_enc;
            r_nerr  <= 2'd0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
`ifdef ECC_FULL_CHANNEL_EN
        S_CHAN: begin
          r_work  <= r_work ^ (r_noise & w_mask);
          r_state <= S_DEC;
        end
`endif
        S_DEC: begin
          r_dout  <= w_dec_data;
          r_nerr  <= w_dec_err;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_out       = r_dout;
  assign num_of_errors  = r_nerr;
  assign operation_done = r_done;
  assign busy           = (r_state != S_IDLE);

endmodule

// File: doc/ecc_enc_dec.md
# ecc_enc_dec

SECDED extended-Hamming codec core, directly downstream of the APB register slave. On `start` it captures `CTRL`, `DATA_IN`, `CODEWORD_WIDTH` and `NOISE`, then performs one of three operations: encode, decode, or full channel (encode, inject noise, decode). It returns the result on `data_out`, reports `num_of_errors`, and pulses `operation_done` once per operation.

## Interface
- `AMBA_WORD`, 32: width of all data/config buses.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle operation request from the register slave.
- `CTRL`  in  AMBA_WORD  `[1:0]` opcode; upper bits ignored.
- `DATA_IN`  in  AMBA_WORD  payload for encode, or codeword for decode.
- `CODEWORD_WIDTH`  in  AMBA_WORD  `[1:0]` selects N: 00=8, 01=16, 10/11=32; upper bits ignored.
- `NOISE`  in  AMBA_WORD  error pattern XORed onto the codeword in full-channel mode.
- `data_out`  out  AMBA_WORD  result, zero-extended above the valid width.
- `num_of_errors`  out  2  0, 1 or 2 detected errors.
- `operation_done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while the FSM is not in IDLE.

## Operation
- **Opcodes:** `CTRL[1:0]` 00=encode, 01=decode, 1x=full channel.
- **Codeword layout, N bits:**
  - Indices 1, 2, 4, 8, 16 (where < N) are parity bits. Parity bit p_n = XOR of all bits m in 1..N-1, m≠n, with (m & n)≠0.
  - The remaining nonzero indices hold data in ascending order, `DATA_IN[0]` at the lowest.
  - Index 0 = XOR of bits 1..N-1 (even overall parity).
  - K data bits: 4 / 11 / 26 for N = 8 / 16 / 32.
- **Encode:** uses `DATA_IN[K-1:0]`; `data_out[N-1:0]` = codeword; `num_of_errors` = 0.
- **Decode:** uses `DATA_IN[N-1:0]`.
  - Syndrome s = XOR of indices n (1..N-1) whose bit is 1; P = XOR of all N bits.
  - s=0, P=0: 0 errors.
  - P=1: 1 error; flip bit s (s=0 flips bit 0).
  - s≠0, P=0: 2 errors; no correction.
  - `data_out[K-1:0]` = extracted data bits.
- **Full channel:** encode, XOR with `NOISE[N-1:0]`, then decode. Outputs are the decode results.
- **FSM states:** IDLE, ENC, CHAN, DEC.
  - IDLE + `start`: capture all inputs. Go to ENC for opcode 00/1x, DEC for 01.
  - ENC: register the codeword into the work register. Go to CHAN (full channel) or finish (encode).
  - CHAN: work ^= masked noise. Go to DEC.
  - DEC: decode the work register (or the captured input). Finish.
  - Finish: `data_out` and `num_of_errors` registered, `operation_done`=1 for one cycle, return to IDLE.
- `start` outside IDLE is ignored; the captured inputs remain stable through the operation.
- `data_out` and `num_of_errors` hold their values until the next completion.
- **Reset values:** `data_out`=0, `num_of_errors`=0, `operation_done`=0, `busy`=0, FSM=IDLE, capture/work registers=0.
- **Reset mid-operation:** the operation is aborted immediately, all outputs return to reset values, and no `operation_done` is issued.

## Timing
- `start` sampled at edge k.
- Encode and decode: results and `operation_done` valid after edge k+1.
- Full channel: results and `operation_done` valid after edge k+3.
- `busy` is high from after edge k until the completing edge.
- Back-to-back: a `start` sampled in the cycle where `operation_done` is high is accepted, since the FSM is already in IDLE.

## Configuration
- **`ECC_FULL_CHANNEL_EN` defined:** full-channel mode is supported as described above; CHAN state present.
- **Not defined:** CHAN state and noise logic are removed.
  - Opcode 1x completes after edge k+1 with `data_out`=0 and `num_of_errors`=0.
  - `NOISE` is unused.

## Test plan
- Encode, N=8, `DATA_IN`=0xB -> `data_out`=0x000000AA, `num_of_errors`=0, `operation_done` pulse after edge k+1.
- Decode, N=8, `DATA_IN`=0xAA -> `data_out`=0xB, `num_of_errors`=0. Same with `DATA_IN`=0xAB (bit 0 flipped) -> `data_out`=0xB, `num_of_errors`=1.
- Full channel, N=8, `DATA_IN`=0xB, `NOISE`=0x10 -> `data_out`=0xB, `num_of_errors`=1, done after edge k+3. With `NOISE`=0x11 -> `num_of_errors`=2, `data_out`=0xB.
- Full channel, N=32, `DATA_IN`=0x3FFFFFF, `NOISE`=0 -> `data_out`=0x3FFFFFF, `num_of_errors`=0. With `NOISE`=0x80000000 -> `data_out`=0x3FFFFFF, `num_of_errors`=1.
- `start` re-asserted while busy -> ignored, exactly one done pulse. `rst` low during CHAN -> all outputs 0, no done, next `start` behaves normally.
- Build without `ECC_FULL_CHANNEL_EN`, `CTRL`=2 -> done after edge k+1, `data_out`=0, `num_of_errors`=0.
